// File: rtl/dmem_ctrl.sv
// Single-port data RAM sequencer/arbiter for the MEM-stage (M) and debug/loader (D) ports, with
// sub-word lanes and read-modify-write stores. Define ALIGN_CHK_EN to flag misaligned M accesses.
module dmem_ctrl #(
  parameter int unsigned AW         = 12,
  parameter int unsigned D_MAX_WAIT = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          m_req,
  input  logic          m_we,
  input  logic [1:0]    m_size,
  input  logic          m_unsigned,
  input  logic [31:0]   m_addr,
  input  logic [31:0]   m_wdata,
  output logic [31:0]   m_rdata,
  output logic          m_done,
  output logic          m_err,
  output logic          m_stall,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [31:0]   d_addr,
  input  logic [31:0]   d_wdata,
  output logic [31:0]   d_rdata,
  output logic          d_done,
  output logic          ram_en,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [31:0]   ram_wdata,
  input  logic [31:0]   ram_rdata,
  output logic          busy
);
  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  state_e        state_q, state_d;
  logic          lat_port_q;  // 1 = D owns the current operation
  logic          lat_we_q, lat_uns_q, lat_err_q;
  logic [1:0]    lat_size_q;
  logic [AW+1:0] lat_addr_q;
  logic [31:0]   lat_wdata_q;
  logic [3:0]    wait_cnt_q;
  logic [31:0]   m_rdata_q, d_rdata_q;

  logic          m_win, d_win, d_starved, m_misalign;
  logic          ram_en_c, ram_we_c;
  logic [31:0]   ram_wdata_c;
  logic [7:0]    rd_byte;
  logic [15:0]   rd_half;
  logic [31:0]   load_val, merged;
  logic          unused_addr;

  assign unused_addr = ^{m_addr[31:AW+2], d_addr[31:AW+2]};

`ifdef ALIGN_CHK_EN
  assign m_misalign = ((m_size == 2'b01) && m_addr[0]) || (m_size[1] && (m_addr[1:0] != 2'b00));
  assign m_err      = m_done & lat_err_q;
`else
  assign m_misalign = 1'b0;
  assign m_err      = 1'b0;
`endif

  assign d_starved = d_req && (wait_cnt_q == 4'(D_MAX_WAIT));
  assign m_win     = m_req && !d_starved;
  assign d_win     = d_req && !m_win;

  always_comb begin
    rd_byte = ram_rdata[{lat_addr_q[1:0], 3'b000} +: 8];
    rd_half = lat_addr_q[1] ? ram_rdata[31:16] : ram_rdata[15:0];
    case (lat_size_q)
      2'b00:   load_val = lat_uns_q ? {24'b0, rd_byte} : {{24{rd_byte[7]}}, rd_byte};
      2'b01:   load_val = lat_uns_q ? {16'b0, rd_half} : {{16{rd_half[15]}}, rd_half};
      default: load_val = ram_rdata;
    endcase
    merged = ram_rdata;
    if (lat_size_q == 2'b00) begin
      merged[{lat_addr_q[1:0], 3'b000} +: 8] = lat_wdata_q[7:0];
    end else if (lat_addr_q[1]) begin
      merged[31:16] = lat_wdata_q[15:0];
    end else begin
      merged[15:0] = lat_wdata_q[15:0];
    end
  end

  always_comb begin
    state_d     = state_q;
    ram_en_c    = 1'b0;
    ram_we_c    = 1'b0;
    ram_wdata_c = '0;
    unique case (state_q)
      StIdle: begin
        if (m_win || d_win) state_d = StIssue;
      end
      StIssue: begin
        if (lat_err_q) begin
          state_d = StResp;
        end else begin
          ram_en_c = 1'b1;
          if (lat_we_q && lat_size_q[1]) begin
            ram_we_c    = 1'b1;
            ram_wdata_c = lat_wdata_q;
            state_d     = StResp;
          end else begin
            state_d = StWait;
          end
        end
      end
      StWait: begin
        if (lat_we_q) begin
          ram_en_c    = 1'b1;
          ram_we_c    = 1'b1;
          ram_wdata_c = merged;
        end
        state_d = StResp;
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      lat_port_q  <= 1'b0;
      lat_we_q    <= 1'b0;
      lat_uns_q   <= 1'b0;
      lat_err_q   <= 1'b0;
      lat_size_q  <= 2'b00;
      lat_addr_q  <= '0;
      lat_wdata_q <= '0;
      wait_cnt_q  <= '0;
      m_rdata_q   <= '0;
      d_rdata_q   <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        StIdle: begin
          if (m_win) begin
            lat_port_q  <= 1'b0;
            lat_we_q    <= m_we;
            lat_size_q  <= m_size;
            lat_uns_q   <= m_unsigned;
            lat_addr_q  <= m_addr[AW+1:0];
            lat_wdata_q <= m_wdata;
            lat_err_q   <= m_misalign;
            if (d_req) wait_cnt_q <= wait_cnt_q + 4'd1;
          end else if (d_win) begin
            lat_port_q  <= 1'b1;
            lat_we_q    <= d_we;
            lat_size_q  <= 2'b10;
            lat_uns_q   <= 1'b0;
            lat_addr_q  <= d_addr[AW+1:0];
            lat_wdata_q <= d_wdata;
            lat_err_q   <= 1'b0;
            wait_cnt_q  <= '0;
          end
        end
        StIssue: begin
          if (lat_err_q) m_rdata_q <= '0;
        end
        StWait: begin
          if (!lat_we_q) begin
            if (lat_port_q) d_rdata_q <= load_val;
            else            m_rdata_q <= load_val;
          end
        end
        default: ;
      endcase
    end
  end

  // Gate RAM strobes with reset so an aborted RMW never writes.
  assign ram_en    = ram_en_c & ~rst;
  assign ram_we    = ram_we_c & ~rst;
  assign ram_addr  = ram_en ? lat_addr_q[AW+1:2] : '0;
  assign ram_wdata = ram_we ? ram_wdata_c : '0;

  assign m_done  = (state_q == StResp) && !lat_port_q && !rst;
  assign d_done  = (state_q == StResp) && lat_port_q && !rst;
  assign m_stall = m_req & ~m_done;
  assign m_rdata = m_rdata_q;
  assign d_rdata = d_rdata_q;
  assign busy    = (state_q != StIdle);
endmodule

// File: tb/tb_dmem_ctrl.sv
// Self-checking bench for dmem_ctrl: table-driven M accesses against a behavioural word RAM,
// D port accesses, reset abort of an RMW, and D starvation arbitration.
module tb_dmem_ctrl;
  localparam int unsigned AW = 12;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          m_req = 1'b0, m_we = 1'b0, m_unsigned = 1'b0;
  logic [1:0]    m_size = 2'b00;
  logic [31:0]   m_addr = '0, m_wdata = '0;
  logic [31:0]   m_rdata;
  logic          m_done, m_err, m_stall;
  logic          d_req = 1'b0, d_we = 1'b0;
  logic [31:0]   d_addr = '0, d_wdata = '0;
  logic [31:0]   d_rdata;
  logic          d_done;
  logic          ram_en, ram_we;
  logic [AW-1:0] ram_addr;
  logic [31:0]   ram_wdata;
  logic [31:0]   ram_rdata = '0;
  logic          busy;

  dmem_ctrl #(.AW(AW), .D_MAX_WAIT(4)) dut (
    .clk(clk), .rst(rst),
    .m_req(m_req), .m_we(m_we), .m_size(m_size), .m_unsigned(m_unsigned), .m_addr(m_addr),
    .m_wdata(m_wdata), .m_rdata(m_rdata), .m_done(m_done), .m_err(m_err), .m_stall(m_stall),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_rdata(d_rdata),
    .d_done(d_done), .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  // Behavioural word RAM with one-cycle registered read and a bench preload port
  logic [31:0]   mem [0:(1<<AW)-1];
  logic          pre_we = 1'b0;
  logic [AW-1:0] pre_idx = '0;
  logic [31:0]   pre_data = '0;
  always @(posedge clk) begin
    if (pre_we) mem[pre_idx] <= pre_data;
    else if (ram_en && ram_we) mem[ram_addr] <= ram_wdata;
    if (ram_en && !ram_we) ram_rdata <= mem[ram_addr];
  end

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] init;
    logic [31:0] exp_rd;
    logic [31:0] exp_word;
    int          lat;
    logic        exp_err;
  } vec_t;

  typedef struct {
    logic [31:0] rd;
    logic [31:0] word;
    int          lat;
    int          we_cyc;
    logic        err;
    logic        en;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] last_m = '0;
  logic [31:0] last_d = '0;
  vec_t        vecs[14];
  vec_t        v;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic preload(input logic [AW-1:0] idx, input logic [31:0] data);
    pre_we = 1'b1; pre_idx = idx; pre_data = data;
    @(posedge clk); #1;
    pre_we = 1'b0;
  endtask

  task automatic m_op(input string name, input vec_t vv);
    exp_t          e, g;
    int            cyc, we_cyc;
    logic          done_seen, stall_ok, en_seen, err;
    logic [31:0]   rd;
    logic [AW-1:0] we_addr;
    preload(vv.addr[AW+1:2], vv.init);
    e.rd     = vv.we ? last_m : vv.exp_rd;
    e.word   = vv.exp_word;
    e.lat    = vv.lat;
    e.err    = vv.exp_err;
    e.en     = !vv.exp_err;
    e.we_cyc = (!vv.we || vv.exp_err) ? -1 : (vv.size[1] ? 1 : 2);
    exp_q.push_back(e);
    if (!vv.we) last_m = vv.exp_rd;
    m_we = vv.we; m_size = vv.size; m_unsigned = vv.uns; m_addr = vv.addr; m_wdata = vv.wdata;
    m_req = 1'b1;
    cyc = 0; we_cyc = -1; done_seen = 1'b0; stall_ok = 1'b1; en_seen = 1'b0;
    err = 1'b0; rd = '0; we_addr = '0;
    while (!done_seen && cyc < 20) begin
      @(negedge clk);
      if (ram_en) en_seen = 1'b1;
      if (ram_en && ram_we && we_cyc < 0) begin
        we_cyc  = cyc;
        we_addr = ram_addr;
      end
      if (m_stall !== !m_done) stall_ok = 1'b0;
      if (m_done) begin
        done_seen = 1'b1; rd = m_rdata; err = m_err;
      end else begin
        cyc++;
      end
    end
    @(posedge clk); #1;
    m_req = 1'b0;
    g = exp_q.pop_front();
    check({name, "_lat"}, 32'(cyc), 32'(g.lat));
    check({name, "_rdata"}, rd, g.rd);
    check({name, "_err"}, 32'(err), 32'(g.err));
    check({name, "_ram_en"}, 32'(en_seen), 32'(g.en));
    check({name, "_we_cycle"}, 32'(we_cyc), 32'(g.we_cyc));
    check({name, "_stall"}, 32'(stall_ok), 32'd1);
    check({name, "_word"}, mem[vv.addr[AW+1:2]], g.word);
    if (g.we_cyc >= 0) check({name, "_we_addr"}, 32'(we_addr), 32'(vv.addr[AW+1:2]));
  endtask

  task automatic d_op(input string name, input logic we, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [31:0] init,
                      input logic [31:0] exp_rd, input logic [31:0] exp_word, input int lat);
    exp_t        e, g;
    int          cyc;
    logic        done_seen;
    logic [31:0] rd;
    preload(addr[AW+1:2], init);
    e.rd = we ? last_d : exp_rd; e.word = exp_word; e.lat = lat;
    e.we_cyc = 0; e.err = 1'b0; e.en = 1'b1;
    exp_q.push_back(e);
    if (!we) last_d = exp_rd;
    d_we = we; d_addr = addr; d_wdata = wdata; d_req = 1'b1;
    cyc = 0; done_seen = 1'b0; rd = '0;
    while (!done_seen && cyc < 20) begin
      @(negedge clk);
      if (d_done) begin
        done_seen = 1'b1; rd = d_rdata;
      end else begin
        cyc++;
      end
    end
    @(posedge clk); #1;
    d_req = 1'b0;
    g = exp_q.pop_front();
    check({name, "_lat"}, 32'(cyc), 32'(g.lat));
    check({name, "_rdata"}, rd, g.rd);
    check({name, "_word"}, mem[addr[AW+1:2]], g.word);
  endtask

  initial begin
    byte grants[6];
    byte exp_g[6];
    int  ng;
    logic [31:0] d_seen_rd;

    //          we    size   uns   addr   wdata          init           exp_rd         exp_word      lat err
    vecs[0]  = '{1'b0, 2'b00, 1'b0, 32'h0D, 32'h0,        32'h8081F2A4, 32'hFFFFFFF2, 32'h8081F2A4, 3, 1'b0};
    vecs[1]  = '{1'b0, 2'b00, 1'b1, 32'h0D, 32'h0,        32'h8081F2A4, 32'h000000F2, 32'h8081F2A4, 3, 1'b0};
    vecs[2]  = '{1'b1, 2'b01, 1'b0, 32'h0E, 32'h0000BEEF, 32'h11223344, 32'h0,        32'hBEEF3344, 3, 1'b0};
    vecs[3]  = '{1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 32'h00000000, 32'h0,        32'hDEADBEEF, 2, 1'b0};
    vecs[4]  = '{1'b0, 2'b01, 1'b0, 32'h0E, 32'h0,        32'h8081F2A4, 32'hFFFF8081, 32'h8081F2A4, 3, 1'b0};
    vecs[5]  = '{1'b0, 2'b01, 1'b1, 32'h0C, 32'h0,        32'h8081F2A4, 32'h0000F2A4, 32'h8081F2A4, 3, 1'b0};
    vecs[6]  = '{1'b0, 2'b10, 1'b0, 32'h0C, 32'h0,        32'h8081F2A4, 32'h8081F2A4, 32'h8081F2A4, 3, 1'b0};
    vecs[7]  = '{1'b1, 2'b00, 1'b0, 32'h13, 32'h0000005A, 32'hDEADBEEF, 32'h0,        32'h5AADBEEF, 3, 1'b0};
    vecs[8]  = '{1'b1, 2'b00, 1'b0, 32'h10, 32'h12345677, 32'hDEADBEEF, 32'h0,        32'hDEADBE77, 3, 1'b0};
    vecs[9]  = '{1'b0, 2'b00, 1'b0, 32'h0F, 32'h0,        32'h8081F2A4, 32'hFFFFFF80, 32'h8081F2A4, 3, 1'b0};
    vecs[10] = '{1'b0, 2'b00, 1'b1, 32'h0C, 32'h0,        32'h8081F2A4, 32'h000000A4, 32'h8081F2A4, 3, 1'b0};
    vecs[11] = '{1'b1, 2'b01, 1'b0, 32'h0C, 32'hFFFF1234, 32'hAABBCCDD, 32'h0,        32'hAABB1234, 3, 1'b0};
    vecs[12] = '{1'b0, 2'b00, 1'b0, 32'h0E, 32'h0,        32'h8081F2A4, 32'hFFFFFF81, 32'h8081F2A4, 3, 1'b0};
    vecs[13] = '{1'b1, 2'b11, 1'b0, 32'h20, 32'h01234567, 32'hFFFFFFFF, 32'h0,        32'h01234567, 2, 1'b0};

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ram_en", 32'(ram_en), 32'd0);
    check("rst_ram_we", 32'(ram_we), 32'd0);
    check("rst_ram_bus", {20'(ram_addr), 12'(ram_wdata != '0)}, 32'd0);
    check("rst_m_rdata", m_rdata, 32'd0);
    check("rst_d_rdata", d_rdata, 32'd0);
    check("rst_flags", {28'd0, m_done, d_done, busy, m_err}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < 14; i++) m_op($sformatf("vec%0d", i), vecs[i]);

    d_op("d_sw", 1'b1, 32'h42, 32'hCAFEF00D, 32'h0, 32'h0, 32'hCAFEF00D, 2);
    d_op("d_lw", 1'b0, 32'h41, 32'h0, 32'hCAFEF00D, 32'hCAFEF00D, 32'hCAFEF00D, 3);

    // Reset during WAIT of a byte store must abort the RMW
    preload(AW'(5), 32'h01020304);
    m_we = 1'b1; m_size = 2'b00; m_unsigned = 1'b0; m_addr = 32'h14; m_wdata = 32'hFF;
    m_req = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    check("rmw_busy_in_wait", 32'(busy), 32'd1);
    rst = 1'b1; m_req = 1'b0;
    @(negedge clk);
    check("rmw_rst_no_we", 32'(ram_we), 32'd0);
    check("rmw_rst_no_done", 32'(m_done), 32'd0);
    @(posedge clk); #1;
    check("rmw_rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    last_m = '0; last_d = '0;
    repeat (2) begin
      @(negedge clk);
      check("rmw_after_no_we", 32'(ram_we), 32'd0);
    end
    check("rmw_word_kept", mem[5], 32'h01020304);
    check("rmw_d_rdata_cleared", d_rdata, 32'd0);
    @(posedge clk); #1;

`ifdef ALIGN_CHK_EN
    v = '{1'b0, 2'b10, 1'b0, 32'h06, 32'h0, 32'h13579BDF, 32'h0, 32'h13579BDF, 2, 1'b1};
`else
    v = '{1'b0, 2'b10, 1'b0, 32'h06, 32'h0, 32'h13579BDF, 32'h13579BDF, 32'h13579BDF, 3, 1'b0};
`endif
    m_op("lw_off6", v);

    // Both ports requesting continuously: D wins after four lost arbitrations
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_g = '{"M", "M", "M", "M", "D", "M"};
    for (int i = 0; i < 6; i++) grants[i] = "-";
    ng = 0; d_seen_rd = '0;
    m_we = 1'b0; m_size = 2'b10; m_addr = 32'h0C; m_req = 1'b1;
    d_we = 1'b0; d_addr = 32'h40; d_req = 1'b1;
    for (int c = 0; c < 300 && ng < 6; c++) begin
      @(negedge clk);
      if (m_done) begin
        grants[ng] = "M"; ng++;
      end else if (d_done) begin
        grants[ng] = "D"; ng++;
        d_seen_rd = d_rdata;
        d_req = 1'b0;
      end
    end
    m_req = 1'b0; d_req = 1'b0;
    for (int i = 0; i < 6; i++) check($sformatf("grant%0d", i), 32'(grants[i]), 32'(exp_g[i]));
    check("arb_d_rdata", d_seen_rd, 32'hCAFEF00D);
    repeat (3) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
